// File: rtl/conv_window_3x3.sv
// conv_window_3x3
//   Builds a sliding 3x3 window over a raster-order image stream and hands
//   complete windows (no padding) to a downstream multiply-accumulate stage.
//   Two line buffers hold the previous two rows; a 3x3 shift register holds
//   the window, which is also the registered output.
//
// Parameters
//   IMG_W, IMG_H : image width / height in pixels (each >= 3)
//
// Ports
//   clk              : clock, rising edge
//   rst              : synchronous active-high reset
//   in_valid/in_ready: input handshake, in_data is a signed 22-bit pixel
//   out_valid/out_ready : output handshake
//   out_w0..out_w8   : window, row-major, w0 top-left, w8 newest pixel
//   out_last         : final window of a frame (only when CONV_WINDOW_LAST_EN
//                      is defined)
//
// Optional feature macro: CONV_WINDOW_LAST_EN
module conv_window_3x3 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [21:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [21:0] out_w0,
  output logic signed [21:0] out_w1,
  output logic signed [21:0] out_w2,
  output logic signed [21:0] out_w3,
  output logic signed [21:0] out_w4,
  output logic signed [21:0] out_w5,
  output logic signed [21:0] out_w6,
  output logic signed [21:0] out_w7,
`ifdef CONV_WINDOW_LAST_EN
  output logic signed [21:0] out_w8,
  output logic               out_last
`else
  output logic signed [21:0] out_w8
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [21:0] line1 [IMG_W];  // previous row
  logic signed [21:0] line2 [IMG_W];  // row before that
  logic signed [21:0] win [9];
  logic in_xfer;
  logic win_done;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  // Requiring row>=2 and col>=2 guarantees every tap comes from the
  // current frame and the current three rows, never a stale line entry.
  assign win_done = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (in_xfer) begin
      // in_xfer implies any pending window has been taken this cycle,
      // so the window may shift and out_valid is simply re-evaluated.
      out_valid <= win_done;
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= line2[col];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= line1[col];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_data;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      line2[col] <= line1[col];
      line1[col] <= in_data;
    end
  end

`ifdef CONV_WINDOW_LAST_EN
  always_ff @(posedge clk) begin
    if (rst)          out_last <= 1'b0;
    else if (in_xfer) out_last <= (row == ROW_LAST) && (col == COL_LAST);
  end
`endif

  assign out_w0 = win[0];
  assign out_w1 = win[1];
  assign out_w2 = win[2];
  assign out_w3 = win[3];
  assign out_w4 = win[4];
  assign out_w5 = win[5];
  assign out_w6 = win[6];
  assign out_w7 = win[7];
  assign out_w8 = win[8];

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3 on a 4x4 image.
module tb_conv_window_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic signed [21:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [21:0] out_w0, out_w1, out_w2, out_w3, out_w4, out_w5, out_w6, out_w7, out_w8;
`ifdef CONV_WINDOW_LAST_EN
  logic out_last;
`endif

  conv_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_w0(out_w0), .out_w1(out_w1), .out_w2(out_w2),
    .out_w3(out_w3), .out_w4(out_w4), .out_w5(out_w5),
    .out_w6(out_w6), .out_w7(out_w7),
`ifdef CONV_WINDOW_LAST_EN
    .out_w8(out_w8), .out_last(out_last)
`else
    .out_w8(out_w8)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // reference model: the current frame as an image, plus expected windows
  int mr, mc;
  logic signed [21:0] img [H][W];
  logic [198:0] expq [$];      // {last, w0..w8}
  logic [197:0] gotq [$];      // windows observed on output transfers
  int n_last, last_idx;
  bit force_rdy;
  int hold_left;

  task automatic chk(input string tag, input logic [198:0] obs, input logic [198:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [197:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {22'(a0), 22'(a1), 22'(a2), 22'(a3), 22'(a4), 22'(a5), 22'(a6), 22'(a7), 22'(a8)};
  endfunction

  function automatic logic [197:0] obs_win();
    return {out_w0, out_w1, out_w2, out_w3, out_w4, out_w5, out_w6, out_w7, out_w8};
  endfunction

  task automatic model_clear();
    mr = 0; mc = 0;
    expq.delete();
    gotq.delete();
    n_last = 0; last_idx = 0;
    hold_left = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input logic signed [21:0] d, output bit acc);
    bit ordy, mrdy, last_e;
    logic [197:0] e;
    ordy = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (out_valid && hold_left > 0) begin
      ordy = 1'b0;
      hold_left--;
    end
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    mrdy = (expq.size() == 0) || ordy;
    chk("out_valid", out_valid, expq.size() != 0);
    chk("in_ready", in_ready, mrdy);
    if (expq.size() != 0) chk("window", obs_win(), expq[0][197:0]);
    if (out_valid && ordy) begin
      gotq.push_back(obs_win());
`ifdef CONV_WINDOW_LAST_EN
      if (expq.size() != 0) chk("out_last", out_last, expq[0][198]);
      if (out_last) begin n_last++; last_idx = gotq.size(); end
`endif
      if (expq.size() != 0) void'(expq.pop_front());
    end
    acc = v && mrdy;
    if (acc) begin
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        e = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
             img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
             img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
        last_e = (mr == H-1) && (mc == W-1);
        expq.push_back({last_e, e});
      end
      mc++;
      if (mc == W) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic signed [21:0] d, input bit gaps);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) step(1'b0, 22'sd0, acc);
      else step(1'b1, d, acc);
      if (gaps && !in_valid) acc = 1'b0;
    end
    if (!acc) begin
      total++;
      $error("FAIL accept_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 40 && expq.size() != 0; i++) step(1'b0, 22'sd0, acc);
    step(1'b0, 22'sd0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_window", obs_win(), '0);
`ifdef CONV_WINDOW_LAST_EN
    chk("rst_out_last", out_last, 1'b0);
`endif
    @(negedge clk);
    model_clear();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    force_rdy = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    // pixels 1..16, always ready
    for (int p = 1; p <= 16; p++) send(22'(p), 1'b0);
    drain();
    chk("basic_count", gotq.size(), 4);
    if (gotq.size() == 4) begin
      chk("basic_first", gotq[0], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk("basic_last", gotq[3], w9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    end

    // 5-cycle stall after first out_valid
    do_reset();
    hold_left = 5;
    for (int p = 1; p <= 16; p++) send(22'(p), 1'b0);
    drain();
    chk("hold_count", gotq.size(), 4);
    chk("hold_used", hold_left, 0);
    if (gotq.size() == 4) chk("hold_first", gotq[0], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    // extreme values pass through untouched
    do_reset();
    for (int p = 1; p <= 16; p++)
      send((p == 6) ? 22'sh3FFFFF : (p == 7) ? 22'sh200000 : 22'(p), 1'b0);
    drain();
    chk("ext_count", gotq.size(), 4);
    if (gotq.size() > 0) begin
      chk("ext_w4", gotq[0][109:88], 22'h3FFFFF);
      chk("ext_w5", gotq[0][87:66], 22'h200000);
    end

    // two frames back-to-back
    do_reset();
    for (int p = 1; p <= 16; p++) send(22'(p), 1'b0);
    for (int p = 101; p <= 116; p++) send(22'(p), 1'b0);
    drain();
    chk("b2b_count", gotq.size(), 8);
    if (gotq.size() == 8) chk("b2b_second_first", gotq[4], w9(101, 102, 103, 105, 106, 107, 109, 110, 111));
`ifdef CONV_WINDOW_LAST_EN
    chk("b2b_last_count", n_last, 2);
`endif

    // reset in the middle of a frame
    do_reset();
    for (int p = 1; p <= 7; p++) send(22'(p + 50), 1'b0);
    do_reset();
    for (int p = 1; p <= 16; p++) send(22'(p), 1'b0);
    drain();
    chk("midrst_count", gotq.size(), 4);
    if (gotq.size() > 0) chk("midrst_first", gotq[0], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
`ifdef CONV_WINDOW_LAST_EN
    chk("midrst_last_count", n_last, 1);
    chk("midrst_last_idx", last_idx, 4);
`endif

    // randomized frames with input gaps and random backpressure
    force_rdy = 1'b0;
    do_reset();
    for (int p = 0; p < 3 * W * H; p++) send(22'($urandom), 1'b1);
    drain();
    chk("rand_count", gotq.size(), 3 * (W-2) * (H-2));
    do_reset();
    for (int p = 0; p < 9; p++) send(22'($urandom), 1'b1);
    do_reset();
    for (int p = 0; p < 2 * W * H; p++) send(22'($urandom), 1'b1);
    drain();
    chk("rand_rst_count", gotq.size(), 2 * (W-2) * (H-2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
